// File: rtl/exec_unit.sv
// Multi-cycle execute unit: ADD/AND/NOT/PASS in one EXEC cycle, MUL by 16-step
// shift-add, then a single WB cycle that writes the register file and updates NZP.
module exec_unit (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [15:0] SR1_In,
  input  logic [15:0] SR2_In,
  input  logic [4:0]  Imm5,
  input  logic        Imm_Sel,
  input  logic [2:0]  DR_In,
  output logic        Busy,
  output logic        Done,
  output logic        LD_REG,
  output logic [2:0]  DR_Out,
  output logic [15:0] Data_Out,
  output logic [2:0]  NZP
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_AND  = 3'b001,
    OP_NOT  = 3'b010,
    OP_PASS = 3'b011,
    OP_MUL  = 3'b100
  } op_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  dr_q, dr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] data_q, data_d;
  logic [2:0]  dr_out_q, dr_out_d;
  logic [2:0]  nzp_q, nzp_d;

  logic [15:0] b_sel;
  logic [15:0] add_term;
  logic        legal;

  assign b_sel    = Imm_Sel ? {{11{Imm5[4]}}, Imm5} : SR2_In;
  assign add_term = b_q[0] ? a_q : '0;
  assign legal    = (op_q <= 3'b100);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    dr_d     = dr_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    acc_d    = acc_q;
    data_d   = data_q;
    dr_out_d = dr_out_q;
    nzp_d    = nzp_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          a_d     = SR1_In;
          b_d     = b_sel;
          op_d    = Op;
          dr_d    = DR_In;
          cnt_d   = '0;
          run_d   = 1'b0;
          acc_d   = '0;
          state_d = (Op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD:  begin data_d = a_q + b_q; dr_out_d = dr_q; end
          OP_AND:  begin data_d = a_q & b_q; dr_out_d = dr_q; end
          OP_NOT:  begin data_d = ~a_q;      dr_out_d = dr_q; end
          OP_PASS: begin data_d = a_q;       dr_out_d = dr_q; end
          default: ;
        endcase
        state_d = S_WB;
      end
      S_MUL: begin
        // First MUL cycle only arms the stepper, so the 16 shift-add steps
        // (counter 0..15) land on the second through seventeenth MUL edges.
        if (!run_q) begin
          run_d = 1'b1;
          acc_d = '0;
        end else begin
          acc_d = acc_q + add_term;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            data_d   = acc_q + add_term;
            dr_out_d = dr_q;
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        if (legal) begin
          if (data_q[15])        nzp_d = 3'b100;
          else if (data_q == '0) nzp_d = 3'b010;
          else                   nzp_d = 3'b001;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      dr_q     <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      acc_q    <= '0;
      data_q   <= '0;
      dr_out_q <= '0;
      nzp_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      dr_q     <= dr_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      dr_out_q <= dr_out_d;
      nzp_q    <= nzp_d;
    end
  end

  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_WB);
  assign LD_REG   = (state_q == S_WB) && legal;
  assign DR_Out   = dr_out_q;
  assign Data_Out = data_q;
  assign NZP      = nzp_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: vector table of single operations plus
// sequences for reserved ops, back-to-back issue, Start during MUL and reset mid-MUL.
module tb_exec_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [2:0]  Op;
  logic [15:0] SR1_In;
  logic [15:0] SR2_In;
  logic [4:0]  Imm5;
  logic        Imm_Sel;
  logic [2:0]  DR_In;
  logic        Busy;
  logic        Done;
  logic        LD_REG;
  logic [2:0]  DR_Out;
  logic [15:0] Data_Out;
  logic [2:0]  NZP;

  int tests = 0;
  int fails = 0;
  int ld_stray = 0;

  exec_unit dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Op       (Op),
    .SR1_In   (SR1_In),
    .SR2_In   (SR2_In),
    .Imm5     (Imm5),
    .Imm_Sel  (Imm_Sel),
    .DR_In    (DR_In),
    .Busy     (Busy),
    .Done     (Done),
    .LD_REG   (LD_REG),
    .DR_Out   (DR_Out),
    .Data_Out (Data_Out),
    .NZP      (NZP)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  imm5;
    logic        sel;
    logic [2:0]  dr;
    logic [15:0] exp_data;
    logic [2:0]  exp_nzp;
    logic        exp_ld;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one op, scramble inputs right after t0, then check WB and the cycle after.
  task automatic run_op(input vec_t v);
    int n;
    logic got;
    @(negedge Clk);
    Op = v.op; SR1_In = v.a; SR2_In = v.b; Imm5 = v.imm5; Imm_Sel = v.sel;
    DR_In = v.dr; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    SR1_In = 16'($urandom); SR2_In = 16'($urandom); Imm5 = 5'($urandom);
    DR_In = 3'($urandom); Op = 3'($urandom); Imm_Sel = 1'($urandom);
    chk({v.name, ".busy"}, 32'(Busy), 32'd1);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge Clk); #1;
      n++;
      if (Done) got = 1'b1;
      else if (LD_REG) ld_stray++;
    end
    chk({v.name, ".latency"}, 32'(n), 32'(v.exp_lat));
    chk({v.name, ".data"}, 32'(Data_Out), 32'(v.exp_data));
    chk({v.name, ".ld_reg"}, 32'(LD_REG), 32'(v.exp_ld));
    if (v.exp_ld) chk({v.name, ".dr_out"}, 32'(DR_Out), 32'(v.dr));
    @(posedge Clk); #1;
    chk({v.name, ".idle"}, {30'd0, Busy, Done}, 32'd0);
    chk({v.name, ".nzp"}, 32'(NZP), 32'(v.exp_nzp));
  endtask

  vec_t tbl[10];
  vec_t v;
  int   n;
  int   dones;
  logic stopped;

  initial begin
    tbl[0] = '{"add_ovf",  3'b000, 16'h7FFF, 16'h0000, 5'h01, 1'b1, 3'd3, 16'h8000, 3'b100, 1'b1, 1};
    tbl[1] = '{"and_zero", 3'b001, 16'hF0F0, 16'h0F0F, 5'h00, 1'b0, 3'd5, 16'h0000, 3'b010, 1'b1, 1};
    tbl[2] = '{"not_zero", 3'b010, 16'h0000, 16'h1234, 5'h00, 1'b0, 3'd1, 16'hFFFF, 3'b100, 1'b1, 1};
    tbl[3] = '{"add_nimm", 3'b000, 16'h0005, 16'h7777, 5'h1E, 1'b1, 3'd2, 16'h0003, 3'b001, 1'b1, 1};
    tbl[4] = '{"add_wrap", 3'b000, 16'hFFFF, 16'h0001, 5'h1F, 1'b0, 3'd4, 16'h0000, 3'b010, 1'b1, 1};
    tbl[5] = '{"mul_a",    3'b100, 16'h0123, 16'h0045, 5'h00, 1'b0, 3'd6, 16'h4E6F, 3'b001, 1'b1, 17};
    tbl[6] = '{"mul_ones", 3'b100, 16'hFFFF, 16'hFFFF, 5'h00, 1'b0, 3'd7, 16'h0001, 3'b001, 1'b1, 17};
    tbl[7] = '{"mul_imm",  3'b100, 16'h0003, 16'h0000, 5'h1F, 1'b1, 3'd0, 16'hFFFD, 3'b100, 1'b1, 17};
    tbl[8] = '{"add_reg",  3'b000, 16'h1000, 16'h0234, 5'h1F, 1'b0, 3'd2, 16'h1234, 3'b001, 1'b1, 1};
    tbl[9] = '{"pass",     3'b011, 16'h5A5A, 16'h0000, 5'h00, 1'b0, 3'd7, 16'h5A5A, 3'b001, 1'b1, 1};

    Reset_n = 1'b0; Start = 1'b0; Op = '0; SR1_In = '0; SR2_In = '0;
    Imm5 = '0; Imm_Sel = 1'b0; DR_In = '0;
    #3;
    chk("reset.outs", {Busy, Done, LD_REG, DR_Out, NZP}, 32'd0);
    chk("reset.data", 32'(Data_Out), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(tbl[i]);

    // Reserved op keeps the previous PASS result and flags.
    v = '{"reserved", 3'b110, 16'h1111, 16'h2222, 5'h00, 1'b0, 3'd1, 16'h5A5A, 3'b001, 1'b0, 1};
    run_op(v);

    // Start held high: one IDLE cycle between back-to-back ops.
    @(negedge Clk);
    Op = 3'b000; SR1_In = 16'h0001; SR2_In = 16'h0002; Imm_Sel = 1'b0; DR_In = 3'd4; Start = 1'b1;
    n = 0;
    do begin @(posedge Clk); #1; n++; end while (!Done && n < 10);
    chk("b2b.first_done", 32'(Done), 32'd1);
    @(posedge Clk); #1;
    chk("b2b.idle_gap", 32'(Busy), 32'd0);
    @(posedge Clk); #1;
    chk("b2b.relaunch", 32'(Busy), 32'd1);
    Start = 1'b0;
    n = 0;
    do begin @(posedge Clk); #1; n++; end while (!Done && n < 10);
    chk("b2b.second_data", 32'(Data_Out), 32'h0003);
    @(posedge Clk); #1;

    // Start pulsed with churning operands during MUL: one Done, t0 operands.
    @(negedge Clk);
    Op = 3'b100; SR1_In = 16'h0123; SR2_In = 16'h0045; Imm_Sel = 1'b0; DR_In = 3'd2; Start = 1'b1;
    @(posedge Clk); #1;
    dones = 0;
    stopped = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (Done) begin
        dones++;
        stopped = 1'b1;
        Start = 1'b0;
        chk("mulchurn.data", 32'(Data_Out), 32'h4E6F);
        chk("mulchurn.dr", 32'(DR_Out), 32'd2);
      end else if (!stopped) begin
        Start = 1'($urandom); SR1_In = 16'($urandom); SR2_In = 16'($urandom);
        Op = 3'($urandom); DR_In = 3'($urandom); Imm_Sel = 1'($urandom);
      end
      @(posedge Clk); #1;
    end
    chk("mulchurn.dones", 32'(dones), 32'd1);

    // Reset during MUL step 8 aborts the op and clears outputs at once.
    @(negedge Clk);
    Op = 3'b100; SR1_In = 16'h00FF; SR2_In = 16'h00FF; Imm_Sel = 1'b0; DR_In = 3'd5; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (8) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst.ctl", {Busy, Done, LD_REG, DR_Out, NZP}, 32'd0);
    chk("midrst.data", 32'(Data_Out), 32'd0);
    n = 0;
    repeat (3) begin @(posedge Clk); #1; if (LD_REG || Done || Busy) n++; end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (20) begin @(posedge Clk); #1; if (LD_REG || Done || Busy) n++; end
    chk("midrst.quiet", 32'(n), 32'd0);
    v = '{"post_rst_add", 3'b000, 16'h0010, 16'h0020, 5'h00, 1'b0, 3'd6, 16'h0030, 3'b001, 1'b1, 1};
    run_op(v);

    chk("ld_outside_wb", 32'(ld_stray), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
